frame_capture_writer: RTL and testbench

//  Write-side counterpart of the pic_rom frame reader. Takes the processed 8-bit

---
 rtl/frame_capture_writer.sv | 79 +++++++
 tb/tb_frame_capture_writer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture_writer.sv
// Frame capture writer: arms on request, locks to the next start-of-frame and
// writes one WIDTH x HEIGHT frame into a single-port RAM in raster order.
module frame_capture_writer #(
   parameter int DATA_WIDTH = 8,
   parameter int WIDTH      = 176,
   parameter int HEIGHT     = 176,
   parameter int ADDR_WIDTH = 15
) (
   input  logic                  pclk,
   input  logic                  reset,
   input  logic                  cap_req,
   input  logic                  pix_valid,
   input  logic                  pix_sof,
   input  logic [DATA_WIDTH-1:0] pix_data,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic                  ram_wren,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  err_flag
);

   localparam int unsigned             NPIX = WIDTH * HEIGHT;
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NPIX - 1);

   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] pix_cnt;
   logic [ADDR_WIDTH-1:0] wr_idx;
   logic                  accept, done_pix, restart_err, arm;

   always_ff @(posedge pclk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cap_req) state_nxt = ARMED;
         ARMED:   if (accept)  state_nxt = done_pix ? IDLE : CAPTURE;
         CAPTURE: if (done_pix) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // sof always lands on index 0, so a sof on the last pixel restarts instead of completing
   always_comb begin
      busy        = (state == ARMED) || (state == CAPTURE);
      arm         = (state == IDLE) && cap_req;
      accept      = pix_valid && ((state == CAPTURE) || ((state == ARMED) && pix_sof));
      wr_idx      = pix_sof ? '0 : pix_cnt;
      done_pix    = accept && (wr_idx == LAST);
      restart_err = (state == CAPTURE) && pix_valid && pix_sof && (pix_cnt != '0);
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         pix_cnt    <= '0;
         ram_addr   <= '0;
         ram_data   <= '0;
         ram_wren   <= 1'b0;
         frame_done <= 1'b0;
         err_flag   <= 1'b0;
      end else begin
         ram_wren   <= accept;
         frame_done <= done_pix;
         if (accept) begin
            ram_addr <= wr_idx;
            ram_data <= pix_data;
            pix_cnt  <= done_pix ? '0 : wr_idx + 1'b1;
         end
         if (arm)              err_flag <= 1'b0;
         else if (restart_err) err_flag <= 1'b1;
      end
   end

endmodule

// File: tb/tb_frame_capture_writer.sv
// Randomized and directed bench for frame_capture_writer against a frame-level
// reference model; a second default-sized instance covers the full 176x176 frame.
module tb_frame_capture_writer;

   localparam int W = 4, H = 3, NPIX = W * H, AW = 4;
   localparam int BNPIX = 176 * 176;

   logic pclk = 1'b0;
   always #5 pclk = ~pclk;

   logic          reset, cap_req, pix_valid, pix_sof;
   logic [7:0]    pix_data;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_data;
   logic          ram_wren, busy, frame_done, err_flag;

   frame_capture_writer #(.DATA_WIDTH(8), .WIDTH(W), .HEIGHT(H), .ADDR_WIDTH(AW)) dut (
      .pclk(pclk), .reset(reset), .cap_req(cap_req), .pix_valid(pix_valid),
      .pix_sof(pix_sof), .pix_data(pix_data), .ram_addr(ram_addr), .ram_data(ram_data),
      .ram_wren(ram_wren), .busy(busy), .frame_done(frame_done), .err_flag(err_flag));

   logic        b_reset, b_cap_req, b_pix_valid, b_pix_sof;
   logic [7:0]  b_pix_data;
   logic [14:0] b_ram_addr;
   logic [7:0]  b_ram_data;
   logic        b_ram_wren, b_busy, b_frame_done, b_err_flag;

   frame_capture_writer dut_big (
      .pclk(pclk), .reset(b_reset), .cap_req(b_cap_req), .pix_valid(b_pix_valid),
      .pix_sof(b_pix_sof), .pix_data(b_pix_data), .ram_addr(b_ram_addr), .ram_data(b_ram_data),
      .ram_wren(b_ram_wren), .busy(b_busy), .frame_done(b_frame_done), .err_flag(b_err_flag));

   int errors = 0, checks = 0;

   // Reference model: mode 0=idle, 1=waiting for sof, 2=inside a frame
   int          m_mode = 0, m_idx = 0;
   logic [15:0] expv;
   logic [AW-1:0] e_addr;
   logic [7:0]  e_data;
   logic        e_wren, e_done, e_err;
   wire  [15:0] obs = {ram_wren, ram_addr, ram_data, frame_done, busy, err_flag};

   task automatic cycle(input logic r, input logic c, input logic v, input logic s,
                        input logic [7:0] d);
      reset = r; cap_req = c; pix_valid = v; pix_sof = s; pix_data = d;
      e_wren = 1'b0; e_done = 1'b0;
      if (r) begin
         m_mode = 0; m_idx = 0; e_addr = '0; e_data = '0; e_err = 1'b0;
      end else if (m_mode == 0) begin
         if (c) begin m_mode = 1; e_err = 1'b0; end
      end else if (v && (m_mode == 2 || s)) begin
         if (s) begin
            if (m_mode == 2 && m_idx != 0) e_err = 1'b1;
            m_idx = 0;
         end
         e_wren = 1'b1; e_addr = AW'(m_idx); e_data = d;
         m_idx++; m_mode = 2;
         if (m_idx == NPIX) begin e_done = 1'b1; m_mode = 0; m_idx = 0; end
      end
      expv = {e_wren, e_addr, e_data, e_done, (m_mode != 0), e_err};
      @(posedge pclk); #1;
   endtask

   task automatic test_reset();
      cycle(1, 1, 1, 1, 8'hAA);
      checks++;
      if (obs !== 16'h0000) begin
         errors++; $display("FAIL reset: got %h exp 0000", obs);
      end
      cycle(1, 0, 0, 0, 8'h00);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL reset_hold: got %h exp %h", obs, expv); end
   endtask

   task automatic test_basic_frame();
      int ndone = 0;
      cycle(0, 1, 0, 0, 8'h00);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL basic_arm: got %h exp %h", obs, expv); end
      for (int i = 0; i < NPIX; i++) begin
         cycle(0, 0, 1, i == 0, 8'(8'h10 + i));
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL basic_px%0d: got %h exp %h", i, obs, expv); end
         if (frame_done) ndone++;
      end
      cycle(0, 0, 0, 0, 8'h00);
      checks++;
      if (ndone !== 1 || busy !== 1'b0 || ram_addr !== AW'(11) || ram_data !== 8'h1B) begin
         errors++; $display("FAIL basic_end: done=%0d busy=%b addr=%0d data=%h exp 1 0 11 1b",
                            ndone, busy, ram_addr, ram_data);
      end
   endtask

   task automatic test_pre_arm();
      for (int i = 0; i < 6; i++) begin
         cycle(0, 0, 1, i == 0, 8'($urandom));
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL prearm_px%0d: got %h exp %h", i, obs, expv); end
      end
      cycle(0, 1, 0, 0, 8'h00);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 8'h00);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL prearm_armed: got %h exp %h", obs, expv); end
      cycle(0, 0, 1, 0, 8'h55);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL prearm_nosof: got %h exp %h", obs, expv); end
      for (int i = 0; i < NPIX; i++) begin
         cycle(0, 0, 1, i == 0, 8'($urandom));
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL prearm_frame%0d: got %h exp %h", i, obs, expv); end
      end
   endtask

   task automatic test_gaps();
      int px = 0;
      cycle(0, 1, 0, 0, 8'h00);
      for (int cyc = 0; cyc < 3 * NPIX + 2; cyc++) begin
         if (cyc % 3 == 0 && px < NPIX) begin
            cycle(0, 0, 1, px == 0, 8'($urandom));
            px++;
         end else cycle(0, 0, 0, 0, 8'($urandom));
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL gaps_cyc%0d: got %h exp %h", cyc, obs, expv); end
      end
   endtask

   task automatic test_mid_sof();
      cycle(0, 1, 0, 0, 8'h00);
      for (int i = 0; i < 5 + NPIX; i++) begin
         cycle(0, 0, 1, i == 0 || i == 5, 8'($urandom));
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL midsof_px%0d: got %h exp %h", i, obs, expv); end
      end
      checks++;
      if (err_flag !== 1'b1 || frame_done !== 1'b1) begin
         errors++; $display("FAIL midsof_flags: err=%b done=%b exp 1 1", err_flag, frame_done);
      end
      cycle(0, 1, 0, 0, 8'h00);
      checks++;
      if (obs !== expv || err_flag !== 1'b0) begin
         errors++; $display("FAIL midsof_clear: got %h exp %h", obs, expv);
      end
      // sof on the final pixel restarts rather than completing
      for (int i = 0; i < NPIX + NPIX; i++) begin
         cycle(0, 0, 1, i == 0 || i == NPIX - 1, 8'($urandom));
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL lastsof_px%0d: got %h exp %h", i, obs, expv); end
      end
   endtask

   task automatic test_reset_mid();
      cycle(0, 1, 0, 0, 8'h00);
      for (int i = 0; i < 7; i++) cycle(0, 0, 1, i == 0, 8'($urandom));
      cycle(1, 0, 1, 0, 8'hEE);
      checks++;
      if (obs !== 16'h0000) begin errors++; $display("FAIL resetmid: got %h exp 0000", obs); end
      cycle(0, 1, 0, 0, 8'h00);
      for (int i = 0; i < NPIX; i++) begin
         cycle(0, 0, 1, i == 0, 8'($urandom));
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL resetmid_px%0d: got %h exp %h", i, obs, expv); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 2000; i++) begin
         cycle($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0, 8'($urandom));
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL random_cyc%0d: got %h exp %h", i, obs, expv); end
      end
   endtask

   task automatic test_full_frame();
      int nwr = 0, ndone = 0;
      b_reset = 1'b1; b_cap_req = 1'b0; b_pix_valid = 1'b0; b_pix_sof = 1'b0; b_pix_data = '0;
      @(posedge pclk); #1;
      b_reset = 1'b0; b_cap_req = 1'b1;
      @(posedge pclk); #1;
      b_cap_req = 1'b0;
      for (int i = 0; i <= BNPIX; i++) begin
         b_pix_valid = (i < BNPIX); b_pix_sof = (i == 0); b_pix_data = 8'(i);
         @(posedge pclk); #1;
         if (b_ram_wren) begin
            checks++;
            if (b_ram_addr !== 15'(nwr) || b_ram_data !== 8'(nwr)) begin
               errors++; $display("FAIL full_wr%0d: addr=%0d data=%h", nwr, b_ram_addr, b_ram_data);
            end
            nwr++;
         end
         if (b_frame_done) begin
            ndone++;
            checks++;
            if (b_ram_addr !== 15'd30975 || b_busy !== 1'b0) begin
               errors++; $display("FAIL full_done: addr=%0d busy=%b exp 30975 0", b_ram_addr, b_busy);
            end
         end
      end
      b_pix_valid = 1'b0;
      @(posedge pclk); #1;
      checks++;
      if (nwr !== BNPIX || ndone !== 1 || b_frame_done !== 1'b0) begin
         errors++; $display("FAIL full_count: writes=%0d done=%0d exp %0d 1", nwr, ndone, BNPIX);
      end
   endtask

   initial begin
      reset = 1'b1; cap_req = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
      e_addr = '0; e_data = '0; e_err = 1'b0; e_wren = 1'b0; e_done = 1'b0; expv = '0;
      b_reset = 1'b1; b_cap_req = 1'b0; b_pix_valid = 1'b0; b_pix_sof = 1'b0; b_pix_data = '0;
      test_reset();
      test_basic_frame();
      test_pre_arm();
      test_gaps();
      test_mid_sof();
      test_reset_mid();
      test_random();
      test_full_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
